// File: rtl/hazard_ctrl_if.sv
// Control bundle between the ID/EXE/MEM pipeline registers and hazard_ctrl.
// No latency of its own; pure wiring.
// No flow control: every signal is sampled every cycle.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       id_src1;
  logic [3:0]       id_src2;
  logic             id_two_src;
  logic             id_src1_valid;
  logic [3:0]       exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic [3:0]       mem_dest;
  logic             mem_wb_en;
  logic             mem_stage_r_en;
  logic             mem_stage_w_en;
  logic             fwd_en;
  logic             branch_taken;
  logic             sram_ready;
  logic             sram_req;
  logic             freeze_pc;
  logic             freeze_if_id;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             freeze_all;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: drives stage information, consumes freeze/flush controls.
  modport master (
    output id_src1, id_src2, id_two_src, id_src1_valid,
    output exe_dest, exe_wb_en, exe_mem_r_en,
    output mem_dest, mem_wb_en, mem_stage_r_en, mem_stage_w_en,
    output fwd_en, branch_taken, sram_ready,
    input  sram_req, freeze_pc, freeze_if_id, flush_if_id, flush_id_ex,
    input  freeze_all, stall_cnt
  );

  // Controller side.
  modport slave (
    input  id_src1, id_src2, id_two_src, id_src1_valid,
    input  exe_dest, exe_wb_en, exe_mem_r_en,
    input  mem_dest, mem_wb_en, mem_stage_r_en, mem_stage_w_en,
    input  fwd_en, branch_taken, sram_ready,
    output sram_req, freeze_pc, freeze_if_id, flush_if_id, flush_id_ex,
    output freeze_all, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/flush control with a RUN/WAIT FSM sequencing SRAM accesses.
// Hazard and branch outputs are combinational (same cycle); SRAM access >= 2 cycles.
// Memory stall freezes the whole pipeline until sram_ready in WAIT; freeze wins over branch and hazard.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  hazard_ctrl_if.slave hc
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_op;
  logic freeze_all_c;
  logic hit_exe, hit_mem;
  logic hazard_raw;
  logic stall_cycle;

  // A destination register matches when either real source operand names it.
  function automatic logic src_hit(input logic [3:0] d,
                                   input logic [3:0] s1, input logic s1_v,
                                   input logic [3:0] s2, input logic s2_v);
    return (s1_v && (d == s1)) || (s2_v && (d == s2));
  endfunction

  // RAW detection: without forwarding any in-flight writer stalls; with it only a load in EXE does.
  always_comb begin
    hit_exe = src_hit(hc.exe_dest, hc.id_src1, hc.id_src1_valid, hc.id_src2, hc.id_two_src);
    hit_mem = src_hit(hc.mem_dest, hc.id_src1, hc.id_src1_valid, hc.id_src2, hc.id_two_src);
    if (hc.fwd_en) begin
      hazard_raw = hc.exe_mem_r_en && hit_exe;
    end else begin
      hazard_raw = (hc.exe_wb_en && hit_exe) || (hc.mem_wb_en && hit_mem);
    end
  end

  // FSM next state and the memory freeze; sram_ready only matters while waiting.
  always_comb begin
    mem_op       = hc.mem_stage_r_en || hc.mem_stage_w_en;
    state_d      = state_q;
    freeze_all_c = 1'b0;
    if (state_q == ST_RUN) begin
      freeze_all_c = mem_op;
      if (mem_op) state_d = ST_WAIT;
    end else begin
      freeze_all_c = !hc.sram_ready;
      if (hc.sram_ready) state_d = ST_RUN;
    end
  end

  // Prioritised outputs: memory freeze, then branch flush, then RAW bubble; all held low in reset.
  always_comb begin
    hc.sram_req     = 1'b0;
    hc.freeze_all   = 1'b0;
    hc.freeze_pc    = 1'b0;
    hc.freeze_if_id = 1'b0;
    hc.flush_if_id  = 1'b0;
    hc.flush_id_ex  = 1'b0;
    if (!rst) begin
      hc.sram_req = (state_q == ST_WAIT);
      if (freeze_all_c) begin
        hc.freeze_all = 1'b1;
      end else if (hc.branch_taken) begin
        // The hazarding ID instruction is discarded, so no freeze is needed.
        hc.flush_if_id = 1'b1;
        hc.flush_id_ex = 1'b1;
      end else if (hazard_raw) begin
        hc.freeze_pc    = 1'b1;
        hc.freeze_if_id = 1'b1;
        hc.flush_id_ex  = 1'b1;
      end
    end
  end

  // Saturating count of cycles lost to memory freezes or RAW bubbles.
  always_comb begin
    stall_cycle = freeze_all_c || (hazard_raw && !hc.branch_taken);
    stall_cnt_d = stall_cnt_q;
    if (stall_cycle && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State and counter registers; reset aborts any SRAM access in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hc.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) bus ();
  hazard_ctrl_if #(.CNT_W(4))  bus4 ();

  hazard_ctrl #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .hc(bus));
  hazard_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .hc(bus4));

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_cnt;

  // {sram_req, freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_all}
  typedef struct {
    logic [3:0] s1;
    logic [3:0] s2;
    logic       two;
    logic       v1;
    logic [3:0] ed;
    logic       ewb;
    logic       er;
    logic [3:0] md;
    logic       mwb;
    logic       fwd;
    logic       br;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [5:0] outs();
    return {bus.sram_req, bus.freeze_pc, bus.freeze_if_id,
            bus.flush_if_id, bus.flush_id_ex, bus.freeze_all};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_in();
    bus.id_src1 = 4'd0;  bus.id_src2 = 4'd0;  bus.id_two_src = 1'b0; bus.id_src1_valid = 1'b0;
    bus.exe_dest = 4'hF; bus.exe_wb_en = 1'b0; bus.exe_mem_r_en = 1'b0;
    bus.mem_dest = 4'hF; bus.mem_wb_en = 1'b0;
    bus.mem_stage_r_en = 1'b0; bus.mem_stage_w_en = 1'b0;
    bus.fwd_en = 1'b0; bus.branch_taken = 1'b0; bus.sram_ready = 1'b0;
  endtask

  task automatic clear_in4();
    bus4.id_src1 = 4'd0;  bus4.id_src2 = 4'd0;  bus4.id_two_src = 1'b0; bus4.id_src1_valid = 1'b0;
    bus4.exe_dest = 4'hF; bus4.exe_wb_en = 1'b0; bus4.exe_mem_r_en = 1'b0;
    bus4.mem_dest = 4'hF; bus4.mem_wb_en = 1'b0;
    bus4.mem_stage_r_en = 1'b0; bus4.mem_stage_w_en = 1'b0;
    bus4.fwd_en = 1'b0; bus4.branch_taken = 1'b0; bus4.sram_ready = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    bus.id_src1 = v.s1; bus.id_src2 = v.s2; bus.id_two_src = v.two; bus.id_src1_valid = v.v1;
    bus.exe_dest = v.ed; bus.exe_wb_en = v.ewb; bus.exe_mem_r_en = v.er;
    bus.mem_dest = v.md; bus.mem_wb_en = v.mwb;
    bus.fwd_en = v.fwd; bus.branch_taken = v.br;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    //            s1    s2    two   v1    ed    ewb   er    md    mwb   fwd   br    exp
    vecs[0]  = '{4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 6'b011010}; // EXE RAW
    vecs[1]  = '{4'd3, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 6'b000000}; // src1 not real
    vecs[2]  = '{4'd0, 4'd7, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 6'b011010}; // MEM RAW on src2
    vecs[3]  = '{4'd0, 4'd7, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 6'b000000}; // MEM no writeback
    vecs[4]  = '{4'd0, 4'd5, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 6'b000000}; // fwd ALU
    vecs[5]  = '{4'd0, 4'd5, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 6'b011010}; // fwd load-use
    vecs[6]  = '{4'd5, 4'd0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 6'b000000}; // fwd MEM dep
    vecs[7]  = '{4'hF, 4'd0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 6'b000000}; // ID/EX reset value
    vecs[8]  = '{4'hF, 4'd0, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 6'b011010}; // R15 dest
    vecs[9]  = '{4'd3, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 6'b000110}; // branch + hazard
    vecs[10] = '{4'd0, 4'd0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 6'b000110}; // branch alone
    vecs[11] = '{4'd0, 4'd3, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 6'b000000}; // src2 not real

    clear_in();
    clear_in4();

    // Outputs are forced low while reset is held, even with a hazard present.
    apply(vecs[0]);
    settle();
    check("outs_in_reset", outs(), 6'b000000);
    tick();
    clear_in();
    do_reset();
    check("reset_outs", outs(), 6'b000000);
    check("reset_cnt", bus.stall_cnt, 0);

    // Table of single-cycle hazard/branch patterns in RUN.
    exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i]);
      settle();
      check($sformatf("vec%0d_outs", i), outs(), vecs[i].exp);
      tick();
      if (vecs[i].exp[4]) exp_cnt++;
      check($sformatf("vec%0d_cnt", i), bus.stall_cnt, exp_cnt);
    end

    // SRAM read: detect, 3 WAIT cycles frozen, release on 4th WAIT cycle.
    clear_in();
    do_reset();
    bus.sram_ready = 1'b1;
    settle();
    check("ready_ignored_run", outs(), 6'b000000);
    tick();
    bus.sram_ready = 1'b0;
    bus.mem_stage_r_en = 1'b1;
    settle();
    check("rd_detect", outs(), 6'b000001);
    tick();
    for (int w = 1; w <= 3; w++) begin
      check($sformatf("rd_wait%0d", w), outs(), 6'b100001);
      tick();
    end
    bus.sram_ready = 1'b1;
    settle();
    check("rd_release", outs(), 6'b100000);
    tick();

    // Back-to-back store enters WAIT with no gap; reset in 2nd WAIT cycle aborts it.
    bus.sram_ready = 1'b0;
    bus.mem_stage_r_en = 1'b0;
    bus.mem_stage_w_en = 1'b1;
    settle();
    check("rd_total_cnt", bus.stall_cnt, 4);
    check("wr_detect_b2b", outs(), 6'b000001);
    tick();
    check("wr_wait1", outs(), 6'b100001);
    tick();
    check("wr_wait2", outs(), 6'b100001);
    rst = 1'b1;
    bus.mem_stage_w_en = 1'b0;
    settle();
    check("wr_rst_forced", outs(), 6'b000000);
    tick();
    rst = 1'b0;
    settle();
    check("abort_outs", outs(), 6'b000000);
    check("abort_cnt", bus.stall_cnt, 0);
    bus.mem_stage_w_en = 1'b1;
    settle();
    check("wr_restart_detect", outs(), 6'b000001);
    tick();
    bus.sram_ready = 1'b1;
    settle();
    check("wr_restart_release", outs(), 6'b100000);
    tick();
    clear_in();
    settle();
    check("wr_restart_cnt", bus.stall_cnt, 1);

    // Branch arriving during a memory stall is deferred to the release cycle.
    bus.mem_stage_r_en = 1'b1;
    tick();
    apply(vecs[9]);
    settle();
    check("br_in_wait", outs(), 6'b100001);
    tick();
    bus.sram_ready = 1'b1;
    settle();
    check("br_at_release", outs(), 6'b100110);
    tick();
    clear_in();
    settle();
    check("br_idle_after", outs(), 6'b000000);
    check("br_cnt", bus.stall_cnt, 3);

    // Saturation on the 4-bit counter instance.
    check("sat_start", bus4.stall_cnt, 0);
    bus4.fwd_en = 1'b0;
    bus4.exe_wb_en = 1'b1;
    bus4.exe_dest = 4'd3;
    bus4.id_src1 = 4'd3;
    bus4.id_src1_valid = 1'b1;
    for (int c = 0; c < 14; c++) tick();
    check("sat_14", bus4.stall_cnt, 14);
    for (int c = 0; c < 6; c++) tick();
    check("sat_20", bus4.stall_cnt, 15);
    check("sat_stall_held", bus4.freeze_pc, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
